// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: run sequencer for a pulse-counter target.
// Each run resets the target, sends TARGET count pulses and then waits for
// done. The outcome is reported as PASS, TIMEOUT, EARLY or ABORT on a
// one-cycle strobe.
//
// state  | meaning
// IDLE   | waiting for start; result_code and pulses_issued hold
// TRST   | tgt_rst high for RST_LEN cycles; done_i ignored
// PULSE  | count_o high for one cycle; pulses_issued increments
// GAPW   | GAP idle cycles between pulses
// WAIT   | all pulses sent; watchdog runs until done_i or TIMEOUT
// REPORT | result_valid strobe for one cycle, then IDLE
module count_seq_ctrl #(
  parameter int CNT_W   = 8,
  parameter int TARGET  = 8,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 64,
  parameter int RST_LEN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             done_i,
  output logic             busy,
  output logic             tgt_rst,
  output logic             count_o,
  output logic [CNT_W-1:0] pulses_issued,
  output logic             result_valid,
  output logic [1:0]       result_code
);

  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam int PH_MAX = (RST_LEN > GAP) ? RST_LEN : GAP;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  // pulses_issued is compared against TARGET-1 so the "+1 == TARGET" test
  // needs no adder on the compare path.
  localparam logic [CNT_W-1:0] LAST_PULSE = CNT_W'(TARGET - 1);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT - 1);
  localparam logic [PH_W-1:0]  RST_LOAD   = PH_W'(RST_LEN - 1);
  localparam logic [PH_W-1:0]  GAP_LOAD   = PH_W'((GAP > 0) ? GAP - 1 : 0);

  localparam logic [1:0] CODE_PASS    = 2'd0;
  localparam logic [1:0] CODE_TIMEOUT = 2'd1;
  localparam logic [1:0] CODE_EARLY   = 2'd2;
  localparam logic [1:0] CODE_ABORT   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRST,
    S_PULSE,
    S_GAPW,
    S_WAIT,
    S_REPORT
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       code_d;
  logic [PH_W-1:0]  ph_cnt;
  logic [WD_W-1:0]  wd_cnt;

  // State register; reset overrides everything, so a mid-run reset gives no strobe.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and result-code selection; abort outranks done_i and timeout.
  always_comb begin
    state_d = state_q;
    code_d  = result_code;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_TRST;
          code_d  = CODE_PASS;
        end
      end
      S_TRST: begin
        if (abort) begin
          state_d = S_REPORT;
          code_d  = CODE_ABORT;
        end else if (ph_cnt == '0) begin
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        if (abort) begin
          state_d = S_REPORT;
          code_d  = CODE_ABORT;
        end else if (done_i) begin
          state_d = S_REPORT;
          code_d  = CODE_EARLY;
        end else if (pulses_issued == LAST_PULSE) begin
          state_d = S_WAIT;
        end else if (GAP > 0) begin
          state_d = S_GAPW;
        end
      end
      S_GAPW: begin
        if (abort) begin
          state_d = S_REPORT;
          code_d  = CODE_ABORT;
        end else if (done_i) begin
          state_d = S_REPORT;
          code_d  = CODE_EARLY;
        end else if (ph_cnt == '0) begin
          state_d = S_PULSE;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_REPORT;
          code_d  = CODE_ABORT;
        end else if (done_i) begin
          state_d = S_REPORT;
          code_d  = CODE_PASS;
        end else if (wd_cnt == WD_LAST) begin
          state_d = S_REPORT;
          code_d  = CODE_TIMEOUT;
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: phase down-counter, watchdog, pulse count and latched result code.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_cnt        <= '0;
      wd_cnt        <= '0;
      pulses_issued <= '0;
      result_code   <= CODE_PASS;
    end else begin
      result_code <= code_d;

      if (state_q == S_IDLE && start)  pulses_issued <= '0;
      else if (state_q == S_PULSE)     pulses_issued <= pulses_issued + CNT_W'(1);

      if (state_d == S_TRST && state_q != S_TRST)      ph_cnt <= RST_LOAD;
      else if (state_d == S_GAPW && state_q != S_GAPW) ph_cnt <= GAP_LOAD;
      else if (ph_cnt != '0)                           ph_cnt <= ph_cnt - PH_W'(1);

      if (state_q == S_WAIT) wd_cnt <= wd_cnt + WD_W'(1);
      else                   wd_cnt <= '0;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign tgt_rst      = (state_q == S_TRST);
  assign count_o      = (state_q == S_PULSE);
  assign result_valid = (state_q == S_REPORT);

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl: default instance with a small target
// model, plus a GAP=0/TARGET=1 instance for the held-start scenario.
module tb_count_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // default instance
  logic       rst_a = 1'b1, start_a = 1'b0, abort_a = 1'b0, done_a;
  logic       busy_a, tgt_rst_a, count_a, rv_a;
  logic [7:0] pulses_a;
  logic [1:0] code_a;

  count_seq_ctrl dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .abort(abort_a), .done_i(done_a),
    .busy(busy_a), .tgt_rst(tgt_rst_a), .count_o(count_a),
    .pulses_issued(pulses_a), .result_valid(rv_a), .result_code(code_a)
  );

  // GAP=0, TARGET=1 instance
  logic       rst_z = 1'b1, start_z = 1'b0, abort_z = 1'b0, done_z = 1'b0;
  logic       busy_z, tgt_rst_z, count_z, rv_z;
  logic [7:0] pulses_z;
  logic [1:0] code_z;

  count_seq_ctrl #(.CNT_W(8), .TARGET(1), .GAP(0), .TIMEOUT(64), .RST_LEN(2)) dut_z (
    .clk(clk), .rst(rst_z), .start(start_z), .abort(abort_z), .done_i(done_z),
    .busy(busy_z), .tgt_rst(tgt_rst_z), .count_o(count_z),
    .pulses_issued(pulses_z), .result_valid(rv_z), .result_code(code_z)
  );

  // target model: counts pulses, cleared by tgt_rst; mode picks done behaviour
  // 0 = done once 8 pulses seen, 1 = stuck at 0, 2 = done once 3 pulses seen
  int         mode = 0;
  logic [7:0] tcnt;

  always_ff @(posedge clk) begin
    if (rst_a || tgt_rst_a) tcnt <= '0;
    else if (count_a)       tcnt <= tcnt + 8'd1;
  end

  always_comb begin
    done_a = 1'b0;
    case (mode)
      0:       done_a = (tcnt >= 8'd8);
      1:       done_a = 1'b0;
      default: done_a = (tcnt >= 8'd3);
    endcase
  end

  // run observations (cycle 1 = first cycle after the start edge)
  int         pcyc[$];
  int         rv_cyc, rv_cnt, trst_cnt;
  logic [1:0] rv_code;
  logic [7:0] rv_pulses;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a run on dut_a and records events; abort is raised during abort_cyc.
  task automatic run_a(input int max_cyc, input int abort_cyc);
    pcyc.delete();
    rv_cyc = -1; rv_cnt = 0; trst_cnt = 0; rv_code = 2'd0; rv_pulses = 8'd0;
    start_a = 1'b1;
    for (int i = 1; i <= max_cyc; i++) begin
      tick();
      start_a = 1'b0;
      abort_a = (i == abort_cyc);
      if (count_a)   pcyc.push_back(i);
      if (tgt_rst_a) trst_cnt++;
      if (rv_a) begin
        rv_cnt++;
        if (rv_cyc < 0) begin
          rv_cyc = i; rv_code = code_a; rv_pulses = pulses_a;
        end
      end
      if (rv_cyc >= 0 && i >= rv_cyc + 2) break;
    end
    abort_a = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_z = 1'b1; start_a = 1'b1;
    tick(); tick(); tick();
    vectors++; if (busy_a !== 1'b0)     begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", busy_a); end
    vectors++; if (tgt_rst_a !== 1'b0)  begin miscompares++; $display("FAIL reset_tgt_rst: got %0b expected 0", tgt_rst_a); end
    vectors++; if (count_a !== 1'b0)    begin miscompares++; $display("FAIL reset_count_o: got %0b expected 0", count_a); end
    vectors++; if (pulses_a !== 8'd0)   begin miscompares++; $display("FAIL reset_pulses: got %0d expected 0", pulses_a); end
    vectors++; if (rv_a !== 1'b0)       begin miscompares++; $display("FAIL reset_result_valid: got %0b expected 0", rv_a); end
    vectors++; if (code_a !== 2'd0)     begin miscompares++; $display("FAIL reset_code: got %0d expected 0", code_a); end
    start_a = 1'b0; rst_a = 1'b0; rst_z = 1'b0;
    tick();
  endtask

  task automatic test_pass();
    int spacing_bad;
    mode = 0;
    run_a(60, 0);
    spacing_bad = 0;
    for (int k = 1; k < pcyc.size(); k++) if (pcyc[k] - pcyc[k-1] != 3) spacing_bad++;
    vectors++; if (pcyc.size() != 8)  begin miscompares++; $display("FAIL pass_pulse_count: got %0d expected 8", pcyc.size()); end
    vectors++; if (pcyc.size() == 0 || pcyc[0] != 3) begin miscompares++; $display("FAIL pass_first_pulse: got %0d expected 3", (pcyc.size() == 0) ? -1 : pcyc[0]); end
    vectors++; if (spacing_bad != 0)  begin miscompares++; $display("FAIL pass_spacing: got %0d bad gaps expected 0", spacing_bad); end
    vectors++; if (trst_cnt != 2)     begin miscompares++; $display("FAIL pass_trst_len: got %0d expected 2", trst_cnt); end
    vectors++; if (rv_cyc != 26)      begin miscompares++; $display("FAIL pass_rv_cycle: got %0d expected 26", rv_cyc); end
    vectors++; if (rv_cnt != 1)       begin miscompares++; $display("FAIL pass_rv_strobes: got %0d expected 1", rv_cnt); end
    vectors++; if (rv_code !== 2'd0)  begin miscompares++; $display("FAIL pass_code: got %0d expected 0", rv_code); end
    vectors++; if (rv_pulses !== 8'd8) begin miscompares++; $display("FAIL pass_pulses: got %0d expected 8", rv_pulses); end
    vectors++; if (busy_a !== 1'b0)   begin miscompares++; $display("FAIL pass_idle_after: got %0b expected 0", busy_a); end
    vectors++; if (pulses_a !== 8'd8) begin miscompares++; $display("FAIL pass_pulses_hold: got %0d expected 8", pulses_a); end
  endtask

  task automatic test_timeout();
    mode = 1;
    run_a(120, 0);
    vectors++; if (rv_cyc != 89)      begin miscompares++; $display("FAIL timeout_rv_cycle: got %0d expected 89", rv_cyc); end
    vectors++; if (rv_code !== 2'd1)  begin miscompares++; $display("FAIL timeout_code: got %0d expected 1", rv_code); end
    vectors++; if (rv_pulses !== 8'd8) begin miscompares++; $display("FAIL timeout_pulses: got %0d expected 8", rv_pulses); end
    vectors++; if (code_a !== 2'd1)   begin miscompares++; $display("FAIL timeout_code_hold: got %0d expected 1", code_a); end
  endtask

  task automatic test_early();
    mode = 2;
    run_a(60, 0);
    vectors++; if (rv_cyc != 11)      begin miscompares++; $display("FAIL early_rv_cycle: got %0d expected 11", rv_cyc); end
    vectors++; if (rv_code !== 2'd2)  begin miscompares++; $display("FAIL early_code: got %0d expected 2", rv_code); end
    vectors++; if (rv_pulses !== 8'd3) begin miscompares++; $display("FAIL early_pulses: got %0d expected 3", rv_pulses); end
    vectors++; if (pcyc.size() != 3)  begin miscompares++; $display("FAIL early_pulse_count: got %0d expected 3", pcyc.size()); end
  endtask

  task automatic test_abort();
    int idle_bad;
    mode = 0;
    run_a(60, 16);
    vectors++; if (rv_cyc != 17)      begin miscompares++; $display("FAIL abort_gap_rv_cycle: got %0d expected 17", rv_cyc); end
    vectors++; if (rv_code !== 2'd3)  begin miscompares++; $display("FAIL abort_gap_code: got %0d expected 3", rv_code); end
    vectors++; if (rv_pulses !== 8'd5) begin miscompares++; $display("FAIL abort_gap_pulses: got %0d expected 5", rv_pulses); end
    vectors++; if (pcyc.size() != 5)  begin miscompares++; $display("FAIL abort_gap_pulse_count: got %0d expected 5", pcyc.size()); end
    // abort coinciding with done in WAIT: abort wins
    run_a(60, 25);
    vectors++; if (rv_cyc != 26)      begin miscompares++; $display("FAIL abort_wait_rv_cycle: got %0d expected 26", rv_cyc); end
    vectors++; if (rv_code !== 2'd3)  begin miscompares++; $display("FAIL abort_wait_code: got %0d expected 3", rv_code); end
    // abort in IDLE: no strobe, no activity
    abort_a = 1'b1;
    idle_bad = 0;
    tick();
    abort_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rv_a !== 1'b0 || busy_a !== 1'b0) idle_bad++;
      tick();
    end
    vectors++; if (idle_bad != 0)     begin miscompares++; $display("FAIL abort_idle_strobe: got %0d active cycles expected 0", idle_bad); end
    vectors++; if (code_a !== 2'd3)   begin miscompares++; $display("FAIL abort_idle_code_hold: got %0d expected 3", code_a); end
  endtask

  task automatic test_mid_rst();
    int rv_seen;
    mode = 0;
    start_a = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      start_a = 1'b0;
    end
    vectors++; if (pulses_a !== 8'd4) begin miscompares++; $display("FAIL midrst_pre_pulses: got %0d expected 4", pulses_a); end
    rst_a = 1'b1;
    tick();
    vectors++; if (busy_a !== 1'b0)    begin miscompares++; $display("FAIL midrst_busy: got %0b expected 0", busy_a); end
    vectors++; if (count_a !== 1'b0)   begin miscompares++; $display("FAIL midrst_count_o: got %0b expected 0", count_a); end
    vectors++; if (tgt_rst_a !== 1'b0) begin miscompares++; $display("FAIL midrst_tgt_rst: got %0b expected 0", tgt_rst_a); end
    vectors++; if (pulses_a !== 8'd0)  begin miscompares++; $display("FAIL midrst_pulses: got %0d expected 0", pulses_a); end
    rst_a = 1'b0;
    rv_seen = (rv_a === 1'b1) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rv_a !== 1'b0) rv_seen++;
    end
    vectors++; if (rv_seen != 0)      begin miscompares++; $display("FAIL midrst_no_strobe: got %0d strobes expected 0", rv_seen); end
    run_a(60, 0);
    vectors++; if (rv_cyc != 26)      begin miscompares++; $display("FAIL midrst_rerun_cycle: got %0d expected 26", rv_cyc); end
    vectors++; if (rv_code !== 2'd0)  begin miscompares++; $display("FAIL midrst_rerun_code: got %0d expected 0", rv_code); end
  endtask

  task automatic test_back_to_back();
    logic exp_busy, exp_cnt, exp_rv, exp_trst;
    start_z = 1'b1;
    done_z  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      done_z   = (i == 1 || i == 2 || i == 4);
      exp_busy = (i != 6);
      exp_cnt  = (i == 3);
      exp_rv   = (i == 5);
      exp_trst = (i == 1 || i == 2 || i == 7 || i == 8);
      vectors++; if (busy_z !== exp_busy)    begin miscompares++; $display("FAIL b2b_busy c%0d: got %0b expected %0b", i, busy_z, exp_busy); end
      vectors++; if (count_z !== exp_cnt)    begin miscompares++; $display("FAIL b2b_count_o c%0d: got %0b expected %0b", i, count_z, exp_cnt); end
      vectors++; if (rv_z !== exp_rv)        begin miscompares++; $display("FAIL b2b_result_valid c%0d: got %0b expected %0b", i, rv_z, exp_rv); end
      vectors++; if (tgt_rst_z !== exp_trst) begin miscompares++; $display("FAIL b2b_tgt_rst c%0d: got %0b expected %0b", i, tgt_rst_z, exp_trst); end
      if (i == 5) begin
        vectors++; if (code_z !== 2'd0)   begin miscompares++; $display("FAIL b2b_code: got %0d expected 0", code_z); end
        vectors++; if (pulses_z !== 8'd1) begin miscompares++; $display("FAIL b2b_pulses: got %0d expected 1", pulses_z); end
      end
    end
    start_z = 1'b0;
    done_z  = 1'b0;
    rst_z   = 1'b1;
    tick();
    rst_z   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000ns");
    $fatal(1, "bench time limit");
  end

  initial begin
    test_reset();
    test_pass();
    test_timeout();
    test_early();
    test_abort();
    test_mid_rst();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
